// File: rtl/lcd_ctrl.sv
// HD44780 16x2 character LCD sequencer: power-up wait, fixed init ROM, then one
// command/data byte per valid/ready handshake with setup, enable-width and execution spacing.
module lcd_ctrl #(
  parameter int PWRUP_CYC    = 750_000,
  parameter int SETUP_CYC    = 3,
  parameter int EN_HIGH_CYC  = 12,
  parameter int CMD_WAIT_CYC = 2_500,
  parameter int CLR_WAIT_CYC = 82_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  input  logic       req_rs_i,
  input  logic [7:0] req_data_i,
  output logic       req_ready_o,
  output logic       init_done_o,
  output logic       busy_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic       lcd_on_o,
  output logic       lcd_blon_o,
  output logic [2:0] dbg_state_o
);

  localparam int MAX_A   = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
  localparam int MAX_B   = (CMD_WAIT_CYC > EN_HIGH_CYC) ? CMD_WAIT_CYC : EN_HIGH_CYC;
  localparam int MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] LD_PWRUP = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] LD_CMD   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] LD_CLR   = CW'(CLR_WAIT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] S_PWRUP  = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ENABLE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_IDLE   = 3'd4;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic          r_init_done;
  logic          r_en;
  logic          r_rs;
  logic [7:0]    r_data;
  logic          r_on;

  logic w_ready;
  logic w_accept;
  logic w_clr;
  logic w_cnt_zero;

  function automatic logic [7:0] f_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    f_rom = 8'h38;
      3'd1:    f_rom = 8'h38;
      3'd2:    f_rom = 8'h0C;
      3'd3:    f_rom = 8'h01;
      3'd4:    f_rom = 8'h06;
      default: f_rom = 8'h00;
    endcase
  endfunction

  // Handshake: a byte transfers at a rising edge where req_valid_i & req_ready_o.
  // Ready is also raised in the final WAIT cycle so a held request goes out with no idle bubble.
  always_comb begin
    w_cnt_zero = (r_cnt == '0);
    w_ready    = (r_state == S_IDLE) ||
                 ((r_state == S_WAIT) && w_cnt_zero && r_init_done);
    w_accept   = req_valid_i && w_ready;
    w_clr      = !r_rs && (r_data[7:2] == 6'd0) && (r_data != 8'd0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_PWRUP;
      r_cnt       <= LD_PWRUP;
      r_idx       <= 3'd0;
      r_init_done <= 1'b0;
      r_en        <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'd0;
      r_on        <= 1'b0;
    end else begin
      r_on <= 1'b1;
      case (r_state)
        S_PWRUP: begin
          if (w_cnt_zero) begin
            r_data  <= f_rom(3'd0);
            r_rs    <= 1'b0;
            r_cnt   <= LD_SETUP;
            r_state <= S_SETUP;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_SETUP: begin
          if (w_cnt_zero) begin
            r_en    <= 1'b1;
            r_cnt   <= LD_EN;
            r_state <= S_ENABLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_ENABLE: begin
          if (w_cnt_zero) begin
            r_en    <= 1'b0;
            r_cnt   <= w_clr ? LD_CLR : LD_CMD;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_WAIT: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else if (!r_init_done) begin
            if (r_idx < 3'd4) begin
              r_idx   <= r_idx + 3'd1;
              r_data  <= f_rom(r_idx + 3'd1);
              r_rs    <= 1'b0;
              r_cnt   <= LD_SETUP;
              r_state <= S_SETUP;
            end else begin
              r_init_done <= 1'b1;
              r_state     <= S_IDLE;
            end
          end else if (w_accept) begin
            r_data  <= req_data_i;
            r_rs    <= req_rs_i;
            r_cnt   <= LD_SETUP;
            r_state <= S_SETUP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_data  <= req_data_i;
            r_rs    <= req_rs_i;
            r_cnt   <= LD_SETUP;
            r_state <= S_SETUP;
          end
        end
        default: begin
          r_en    <= 1'b0;
          r_cnt   <= LD_PWRUP;
          r_state <= S_PWRUP;
        end
      endcase
    end
  end

  assign req_ready_o = w_ready;
  assign busy_o      = !w_ready;
  assign init_done_o = r_init_done;
  assign lcd_data_o  = r_data;
  assign lcd_rs_o    = r_rs;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = r_en;
  assign lcd_on_o    = r_on;
  assign lcd_blon_o  = 1'b0;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed and randomised bench for lcd_ctrl with shortened timing parameters;
// a negedge monitor records every EN pulse and checks RS/DATA hold while EN is high and during WAIT.
module tb_lcd_ctrl;

  localparam int P_PWRUP = 20;
  localparam int P_SETUP = 2;
  localparam int P_EN    = 4;
  localparam int P_CMD   = 10;
  localparam int P_CLR   = 30;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       req_valid_i = 1'b0;
  logic       req_rs_i = 1'b0;
  logic [7:0] req_data_i = 8'd0;
  logic       req_ready_o, init_done_o, busy_o;
  logic [7:0] lcd_data_o;
  logic       lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, lcd_blon_o;
  logic [2:0] dbg_state_o;

  lcd_ctrl #(
    .PWRUP_CYC(P_PWRUP), .SETUP_CYC(P_SETUP), .EN_HIGH_CYC(P_EN),
    .CMD_WAIT_CYC(P_CMD), .CLR_WAIT_CYC(P_CLR)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_rs_i(req_rs_i),
    .req_data_i(req_data_i), .req_ready_o(req_ready_o), .init_done_o(init_done_o),
    .busy_o(busy_o), .lcd_data_o(lcd_data_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o),
    .lcd_en_o(lcd_en_o), .lcd_on_o(lcd_on_o), .lcd_blon_o(lcd_blon_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int t_rel = 0;

  typedef struct {
    int         rise;
    int         fall;
    logic [7:0] data;
    logic       rs;
  } pulse_t;

  pulse_t     pulses[$];
  pulse_t     cur = '{rise: 0, fall: 0, data: 8'd0, rs: 1'b0};
  logic       prev_en = 1'b0;
  int         last_fall = -1000;
  int         hold_err = 0;

  logic [8:0] exp_q[$];
  int         acc_q[$];

  logic [7:0] rom [5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  int         init_rise [5] = '{22, 38, 54, 70, 106};

  // EN pulse monitor; no byte may be reloaded earlier than the shortest wait after EN falls
  always @(negedge clk) begin
    if (lcd_en_o && !prev_en) begin
      cur.rise = cyc;
      cur.data = lcd_data_o;
      cur.rs   = lcd_rs_o;
    end else if (lcd_en_o) begin
      if ({lcd_rs_o, lcd_data_o} !== {cur.rs, cur.data}) hold_err++;
    end else if (prev_en) begin
      cur.fall = cyc;
      pulses.push_back(cur);
      last_fall = cyc;
      cur.rs   = lcd_rs_o;
      cur.data = lcd_data_o;
    end else if (cyc < last_fall + P_CMD && {lcd_rs_o, lcd_data_o} !== {cur.rs, cur.data}) begin
      hold_err++;
    end
    prev_en = lcd_en_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // driver tasks
  task automatic test_reset();
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (lcd_en_o !== 1'b0)      begin n_err++; $display("FAIL rst_en got %b want 0", lcd_en_o); end
    n_vec++; if (busy_o !== 1'b1)        begin n_err++; $display("FAIL rst_busy got %b want 1", busy_o); end
    n_vec++; if (req_ready_o !== 1'b0)   begin n_err++; $display("FAIL rst_ready got %b want 0", req_ready_o); end
    n_vec++; if (init_done_o !== 1'b0)   begin n_err++; $display("FAIL rst_init_done got %b want 0", init_done_o); end
    n_vec++; if (lcd_on_o !== 1'b0)      begin n_err++; $display("FAIL rst_on got %b want 0", lcd_on_o); end
    n_vec++; if (lcd_data_o !== 8'd0)    begin n_err++; $display("FAIL rst_data got %h want 00", lcd_data_o); end
    n_vec++; if (lcd_rs_o !== 1'b0)      begin n_err++; $display("FAIL rst_rs got %b want 0", lcd_rs_o); end
    n_vec++; if (lcd_rw_o !== 1'b0)      begin n_err++; $display("FAIL rst_rw got %b want 0", lcd_rw_o); end
    n_vec++; if (lcd_blon_o !== 1'b0)    begin n_err++; $display("FAIL rst_blon got %b want 0", lcd_blon_o); end
    rst_i = 1'b0;
    t_rel = cyc;
    pulses.delete();
    @(negedge clk);
    n_vec++; if (lcd_on_o !== 1'b1)      begin n_err++; $display("FAIL on_after_release got %b want 1", lcd_on_o); end
    n_vec++; if (busy_o !== 1'b1)        begin n_err++; $display("FAIL busy_in_pwrup got %b want 1", busy_o); end
  endtask

  // init sequence timing; a 0x55 request is held valid throughout and must be ignored
  task automatic test_init();
    req_valid_i = 1'b1;
    req_rs_i    = 1'b1;
    req_data_i  = 8'h55;
    while (cyc < t_rel + 119) @(negedge clk);
    n_vec++; if (init_done_o !== 1'b0)   begin n_err++; $display("FAIL init_done_early got %b want 0", init_done_o); end
    n_vec++; if (req_ready_o !== 1'b0)   begin n_err++; $display("FAIL ready_early got %b want 0", req_ready_o); end
    req_valid_i = 1'b0;
    @(negedge clk);
    n_vec++; if (init_done_o !== 1'b1)   begin n_err++; $display("FAIL init_done_120 got %b want 1", init_done_o); end
    n_vec++; if (req_ready_o !== 1'b1)   begin n_err++; $display("FAIL ready_120 got %b want 1", req_ready_o); end
    n_vec++; if (busy_o !== 1'b0)        begin n_err++; $display("FAIL busy_120 got %b want 0", busy_o); end
    n_vec++; if (pulses.size() !== 5)    begin n_err++; $display("FAIL init_pulse_count got %0d want 5", pulses.size()); end
    for (int k = 0; k < 5 && k < pulses.size(); k++) begin
      n_vec++; if (pulses[k].data !== rom[k]) begin n_err++; $display("FAIL init_data[%0d] got %h want %h", k, pulses[k].data, rom[k]); end
      n_vec++; if (pulses[k].rs !== 1'b0)     begin n_err++; $display("FAIL init_rs[%0d] got %b want 0", k, pulses[k].rs); end
      n_vec++; if (pulses[k].rise !== t_rel + init_rise[k]) begin
        n_err++; $display("FAIL init_rise[%0d] got %0d want %0d", k, pulses[k].rise - t_rel, init_rise[k]);
      end
      n_vec++; if (pulses[k].fall - pulses[k].rise !== P_EN) begin
        n_err++; $display("FAIL init_width[%0d] got %0d want %0d", k, pulses[k].fall - pulses[k].rise, P_EN);
      end
    end
    n_vec++; if (hold_err !== 0)         begin n_err++; $display("FAIL init_hold got %0d want 0", hold_err); end
  endtask

  task automatic test_data_write();
    int t;
    pulses.delete();
    @(negedge clk);
    req_valid_i = 1'b1;
    req_rs_i    = 1'b1;
    req_data_i  = 8'h41;
    t = cyc + 1;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_data_i  = 8'hAA;
    n_vec++; if (req_ready_o !== 1'b0)   begin n_err++; $display("FAIL dw_ready_drop got %b want 0", req_ready_o); end
    while (cyc < t + 14) @(negedge clk);
    n_vec++; if (req_ready_o !== 1'b0)   begin n_err++; $display("FAIL dw_ready_t14 got %b want 0", req_ready_o); end
    // ready is seen in the cycle just before the T+16 edge, which is the edge that can accept
    @(negedge clk);
    n_vec++; if (req_ready_o !== 1'b1)   begin n_err++; $display("FAIL dw_ready_t16 got %b want 1", req_ready_o); end
    n_vec++; if ({lcd_rs_o, lcd_data_o} !== 9'h141) begin
      n_err++; $display("FAIL dw_hold got %h want 141", {lcd_rs_o, lcd_data_o});
    end
    @(negedge clk);
    n_vec++; if (req_ready_o !== 1'b1)   begin n_err++; $display("FAIL dw_idle_ready got %b want 1", req_ready_o); end
    n_vec++; if (pulses.size() !== 1)    begin n_err++; $display("FAIL dw_count got %0d want 1", pulses.size()); end
    if (pulses.size() > 0) begin
      n_vec++; if (pulses[0].rise !== t + 2) begin n_err++; $display("FAIL dw_rise got %0d want %0d", pulses[0].rise - t, 2); end
      n_vec++; if (pulses[0].fall !== t + 6) begin n_err++; $display("FAIL dw_fall got %0d want %0d", pulses[0].fall - t, 6); end
      n_vec++; if ({pulses[0].rs, pulses[0].data} !== 9'h141) begin
        n_err++; $display("FAIL dw_byte got %h want 141", {pulses[0].rs, pulses[0].data});
      end
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2, k;
    pulses.delete();
    @(negedge clk);
    req_valid_i = 1'b1;
    req_rs_i    = 1'b0;
    req_data_i  = 8'h01;
    t1 = cyc + 1;
    @(negedge clk);
    req_data_i = 8'h80;
    k = 0;
    while (req_ready_o !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    t2 = cyc + 1;
    n_vec++; if (t2 - t1 !== 36)         begin n_err++; $display("FAIL b2b_accept_gap got %0d want 36", t2 - t1); end
    @(negedge clk);
    req_valid_i = 1'b0;
    n_vec++; if (req_ready_o !== 1'b0)   begin n_err++; $display("FAIL b2b_ready_drop got %b want 0", req_ready_o); end
    k = 0;
    while (req_ready_o !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    n_vec++; if (cyc + 1 - t2 !== 16)    begin n_err++; $display("FAIL b2b_complete got %0d want 16", cyc + 1 - t2); end
    n_vec++; if (pulses.size() !== 2)    begin n_err++; $display("FAIL b2b_count got %0d want 2", pulses.size()); end
    if (pulses.size() == 2) begin
      n_vec++; if ({pulses[0].rs, pulses[0].data} !== 9'h001) begin n_err++; $display("FAIL b2b_byte0 got %h want 001", {pulses[0].rs, pulses[0].data}); end
      n_vec++; if (pulses[0].rise !== t1 + 2) begin n_err++; $display("FAIL b2b_rise0 got %0d want 2", pulses[0].rise - t1); end
      n_vec++; if ({pulses[1].rs, pulses[1].data} !== 9'h080) begin n_err++; $display("FAIL b2b_byte1 got %h want 080", {pulses[1].rs, pulses[1].data}); end
      n_vec++; if (pulses[1].rise !== t2 + 2) begin n_err++; $display("FAIL b2b_rise1 got %0d want 2", pulses[1].rise - t2); end
      n_vec++; if (pulses[1].fall !== t2 + 6) begin n_err++; $display("FAIL b2b_fall1 got %0d want 6", pulses[1].fall - t2); end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_rs_i    = 1'b1;
    req_data_i  = 8'h41;
    @(negedge clk);
    req_valid_i = 1'b0;
    k = 0;
    while (lcd_en_o !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    n_vec++; if (lcd_en_o !== 1'b1)      begin n_err++; $display("FAIL mid_en_seen got %b want 1", lcd_en_o); end
    rst_i = 1'b1;
    @(negedge clk);
    n_vec++; if (lcd_en_o !== 1'b0)      begin n_err++; $display("FAIL mid_en_forced got %b want 0", lcd_en_o); end
    n_vec++; if (init_done_o !== 1'b0)   begin n_err++; $display("FAIL mid_init_done got %b want 0", init_done_o); end
    n_vec++; if (busy_o !== 1'b1)        begin n_err++; $display("FAIL mid_busy got %b want 1", busy_o); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    t_rel = cyc;
    pulses.delete();
  endtask

  task automatic test_random();
    int k, w;
    logic [8:0] e;
    pulses.delete();
    exp_q.delete();
    acc_q.delete();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      req_valid_i = ($urandom_range(0, 2) != 0);
      req_rs_i    = 1'($urandom_range(0, 1));
      req_data_i  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      if (req_valid_i && req_ready_o) begin
        exp_q.push_back({req_rs_i, req_data_i});
        acc_q.push_back(cyc + 1);
      end
    end
    @(negedge clk);
    req_valid_i = 1'b0;
    k = 0;
    while (req_ready_o !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    n_vec++; if (pulses.size() !== exp_q.size()) begin
      n_err++; $display("FAIL rnd_count got %0d want %0d", pulses.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < pulses.size(); i++) begin
      e = exp_q[i];
      n_vec++; if ({pulses[i].rs, pulses[i].data} !== e) begin
        n_err++; $display("FAIL rnd_byte[%0d] got %h want %h", i, {pulses[i].rs, pulses[i].data}, e);
      end
      n_vec++; if (pulses[i].rise !== acc_q[i] + P_SETUP) begin
        n_err++; $display("FAIL rnd_rise[%0d] got %0d want %0d", i, pulses[i].rise - acc_q[i], P_SETUP);
      end
      n_vec++; if (pulses[i].fall - pulses[i].rise !== P_EN) begin
        n_err++; $display("FAIL rnd_width[%0d] got %0d want %0d", i, pulses[i].fall - pulses[i].rise, P_EN);
      end
      if (i > 0) begin
        e = exp_q[i-1];
        w = (!e[8] && e[7:2] == 6'd0 && e[7:0] != 8'd0) ? P_CLR : P_CMD;
        n_vec++; if (acc_q[i] - acc_q[i-1] < P_SETUP + P_EN + w) begin
          n_err++; $display("FAIL rnd_gap[%0d] got %0d want >= %0d", i, acc_q[i] - acc_q[i-1], P_SETUP + P_EN + w);
        end
      end
    end
    n_vec++; if (hold_err !== 0)         begin n_err++; $display("FAIL rnd_hold got %0d want 0", hold_err); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_data_write();
    test_back_to_back();
    test_reset_mid();
    test_init();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
